// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-cache port with request/response handshake,
// pipeline stall, load alignment/extension and access/stall counters.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic        flush,
   input  logic        dcache_resp,
   input  logic [31:0] dcache_rdata,
   output logic        dcache_read,
   output logic        dcache_write,
   output logic [31:0] dcache_address,
   output logic [3:0]  dcache_mbe,
   output logic [31:0] dcache_wdata,
   output logic        stall_mem,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic [31:0] access_count,
   output logic [31:0] stall_count
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, next_state;
   logic        acc, mis_cond, req, idle_req, accept;
   logic        l_rd, l_wr, l_flush;
   logic [2:0]  l_f3, c_f3;
   logic [1:0]  l_off, c_off;
   logic [3:0]  l_mbe;
   logic [31:0] l_addr, l_wdata, shifted, ext;
   // rst_n gates the combinational request path so outputs drop the moment reset asserts
   assign acc      = rst_n & valid & (mem_read | mem_write);
   assign mis_cond = (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) || (funct3[1:0] == 2'b01 && addr[0]);
   assign req      = acc & ~mis_cond & ~flush;
   assign idle_req = (state == IDLE) & req;
   assign accept   = dcache_resp & stall_mem;
   assign c_f3     = (state == IDLE) ? funct3 : l_f3;
   assign c_off    = (state == IDLE) ? addr[1:0] : l_off;
   assign shifted  = dcache_rdata >> {c_off, 3'b000};
   always_comb begin
      ext = c_f3[1] ? shifted :
            c_f3[0] ? {{16{~c_f3[2] & shifted[15]}}, shifted[15:0]} :
                      {{24{~c_f3[2] & shifted[7]}}, shifted[7:0]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end
   always_comb begin
      next_state = (state == DONE) ? IDLE :
                   (state == BUSY) ? (dcache_resp ? DONE : BUSY) :
                   idle_req        ? (dcache_resp ? DONE : BUSY) : IDLE;
   end
   always_comb begin
      dcache_read    = 1'b0;
      dcache_write   = 1'b0;
      dcache_address = 32'h0;
      dcache_mbe     = 4'h0;
      dcache_wdata   = 32'h0;
      stall_mem      = 1'b0;
      if (idle_req) begin
         dcache_read    = mem_read;
         dcache_write   = mem_write;
         dcache_address = {addr[31:2], 2'b00};
         dcache_mbe     = mem_byte_enable;
         dcache_wdata   = store_data << {addr[1:0], 3'b000};
         stall_mem      = 1'b1;
      end else if (state == BUSY) begin
         dcache_read    = l_rd;
         dcache_write   = l_wr;
         dcache_address = l_addr;
         dcache_mbe     = l_mbe;
         dcache_wdata   = l_wdata;
         stall_mem      = 1'b1;
      end
      misaligned = (state == IDLE) & acc & mis_cond;
      load_valid = (state == DONE) & l_rd & ~l_flush & ~flush;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l_rd         <= 1'b0;
         l_wr         <= 1'b0;
         l_flush      <= 1'b0;
         l_f3         <= 3'b0;
         l_off        <= 2'b0;
         l_mbe        <= 4'h0;
         l_addr       <= 32'h0;
         l_wdata      <= 32'h0;
         load_data    <= 32'h0;
         access_count <= 32'h0;
         stall_count  <= 32'h0;
      end else begin
         if (idle_req) begin
            l_rd    <= mem_read;
            l_wr    <= mem_write;
            l_flush <= 1'b0;
            l_f3    <= funct3;
            l_off   <= addr[1:0];
            l_mbe   <= mem_byte_enable;
            l_addr  <= {addr[31:2], 2'b00};
            l_wdata <= store_data << {addr[1:0], 3'b000};
         end else if (state == BUSY && flush) begin
            l_flush <= 1'b1;
         end
         if (accept) begin
            load_data    <= ext;
            access_count <= access_count + 32'd1;
         end
         if (stall_mem) stall_count <= stall_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed accesses with a load-data scoreboard and counter model.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, flush = 1'b0, dcache_resp = 1'b0;
   logic [3:0]  mem_byte_enable = 4'h0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] addr = 32'h0, store_data = 32'h0, dcache_rdata = 32'h0;
   logic        dcache_read, dcache_write, stall_mem, load_valid, misaligned;
   logic [31:0] dcache_address, dcache_wdata, load_data, access_count, stall_count;
   logic [3:0]  dcache_mbe;
   int          checks = 0, errors = 0;
   logic [31:0] exp_acc = 0, exp_stc = 0;
   logic [31:0] sb[$];

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .funct3(funct3), .addr(addr), .store_data(store_data),
      .flush(flush), .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
      .dcache_read(dcache_read), .dcache_write(dcache_write), .dcache_address(dcache_address),
      .dcache_mbe(dcache_mbe), .dcache_wdata(dcache_wdata), .stall_mem(stall_mem),
      .load_data(load_data), .load_valid(load_valid), .misaligned(misaligned),
      .access_count(access_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [3:0] be);
      valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
      store_data = sd; mem_byte_enable = be;
   endtask

   task automatic idle_inputs();
      valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0; dcache_resp = 1'b0;
   endtask

   // called at 1 time unit after a rising edge; returns at the same phase after DONE
   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [3:0] be,
                         input logic [31:0] rdata, input int lat, input int flush_at,
                         input int exp_st, input logic [31:0] exp_wd, input int exp_lv,
                         input logic [31:0] exp_ld);
      int st = 0, rq = 0, lv = 0, done = 0;
      if (exp_lv != 0) sb.push_back(exp_ld);
      drive(rd, wr, f3, a, sd, be);
      for (int i = 0; i < 20 && done == 0; i++) begin
         dcache_resp  = (i >= lat);
         dcache_rdata = (i == lat) ? rdata : $urandom;
         flush        = (i == flush_at);
         #1;
         if (i == 0) begin
            chk({tag, " address"}, dcache_address, {a[31:2], 2'b00});
            chk({tag, " mbe"}, {28'h0, dcache_mbe}, {28'h0, be});
            if (wr) chk({tag, " wdata"}, dcache_wdata, exp_wd);
         end
         st += int'(stall_mem);
         rq += int'(dcache_read | dcache_write);
         if (load_valid) begin
            lv++;
            if (sb.size() == 0) chk({tag, " unexpected load_valid"}, {31'h0, load_valid}, 32'h0);
            else chk({tag, " load_data"}, load_data, sb.pop_front());
         end
         if (!stall_mem) done = 1;
         @(posedge clk); #1;
      end
      idle_inputs();
      exp_acc += 1;
      exp_stc += 32'(exp_st);
      chk({tag, " reached DONE"}, 32'(done), 32'd1);
      chk({tag, " stall cycles"}, 32'(st), 32'(exp_st));
      chk({tag, " request cycles"}, 32'(rq), 32'(exp_st));
      chk({tag, " load_valid cycles"}, 32'(lv), 32'(exp_lv));
      chk({tag, " access_count"}, access_count, exp_acc);
      chk({tag, " stall_count"}, stall_count, exp_stc);
   endtask

   task automatic misalign(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a);
      drive(rd, wr, f3, a, 32'h12345678, 4'hF);
      #1;
      chk({tag, " misaligned"}, {31'h0, misaligned}, 32'h1);
      chk({tag, " no request"}, {30'h0, dcache_read, dcache_write}, 32'h0);
      chk({tag, " no stall"}, {31'h0, stall_mem}, 32'h0);
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk({tag, " pulse ends"}, {31'h0, misaligned}, 32'h0);
      chk({tag, " access_count"}, access_count, exp_acc);
      chk({tag, " stall_count"}, stall_count, exp_stc);
      @(posedge clk); #1;
   endtask

   initial begin
      @(posedge clk); #1;
      chk("reset stall_mem", {31'h0, stall_mem}, 32'h0);
      chk("reset requests", {30'h0, dcache_read, dcache_write}, 32'h0);
      chk("reset address", dcache_address, 32'h0);
      chk("reset load_data", load_data, 32'h0);
      chk("reset load_valid", {31'h0, load_valid}, 32'h0);
      chk("reset access_count", access_count, 32'h0);
      chk("reset stall_count", stall_count, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      access("lw",  1, 0, 3'b010, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 3, -1, 4, 32'h0, 1, 32'hDEADBEEF);
      access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 4'h8, 32'h80112233, 0, -1, 1, 32'h0, 1, 32'hFFFFFF80);
      access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 4'h8, 32'h80112233, 1, -1, 2, 32'h0, 1, 32'h00000080);
      access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 4'hC, 32'h80112233, 2, -1, 3, 32'h0, 1, 32'h00008011);
      access("lh",  1, 0, 3'b001, 32'h102, 32'h0, 4'hC, 32'h80112233, 0, -1, 1, 32'h0, 1, 32'hFFFF8011);
      access("lb0", 1, 0, 3'b000, 32'h100, 32'h0, 4'h1, 32'h8011227F, 1, -1, 2, 32'h0, 1, 32'h0000007F);
      access("sh",  0, 1, 3'b001, 32'h206, 32'h0000ABCD, 4'hC, 32'h0, 0, -1, 1, 32'hABCD0000, 0, 32'h0);
      access("sb",  0, 1, 3'b000, 32'h205, 32'h000000EE, 4'h2, 32'h0, 2, -1, 3, 32'h0000EE00, 0, 32'h0);
      access("flush", 1, 0, 3'b010, 32'h108, 32'h0, 4'hF, 32'hCAFEF00D, 2, 1, 3, 32'h0, 0, 32'h0);
      misalign("lw101", 1, 0, 3'b010, 32'h101);
      misalign("sh203", 0, 1, 3'b001, 32'h203);
      // request held in BUSY while the inputs wander, then reset lands mid-transaction
      drive(1, 0, 3'b010, 32'h300, 32'h0, 4'hF);
      #1;
      chk("hold issue read", {31'h0, dcache_read}, 32'h1);
      @(posedge clk); #1;
      drive(0, 1, 3'b000, 32'h404, 32'h55555555, 4'h1);
      #1;
      chk("hold address", dcache_address, 32'h300);
      chk("hold read/write", {30'h0, dcache_read, dcache_write}, 32'h2);
      chk("hold mbe", {28'h0, dcache_mbe}, 32'hF);
      chk("hold wdata", dcache_wdata, 32'h0);
      chk("hold stall", {31'h0, stall_mem}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst stall", {31'h0, stall_mem}, 32'h0);
      chk("async rst requests", {30'h0, dcache_read, dcache_write}, 32'h0);
      chk("async rst address", dcache_address, 32'h0);
      chk("async rst wdata", dcache_wdata, 32'h0);
      chk("async rst mbe", {28'h0, dcache_mbe}, 32'h0);
      chk("async rst load_data", load_data, 32'h0);
      chk("async rst access_count", access_count, 32'h0);
      chk("async rst stall_count", stall_count, 32'h0);
      idle_inputs();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      exp_acc = 0;
      exp_stc = 0;
      access("post-rst lw", 1, 0, 3'b010, 32'h40C, 32'h0, 4'hF, 32'h0BADF00D, 1, -1, 2, 32'h0, 1, 32'h0BADF00D);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
